mdu_scheduler: RTL and testbench
================================

# mdu_scheduler

Schedules the shared multi-cycle multiply/divide unit (MDU) of the 5-stage pipeline and owns the architectural HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo from the EX stage, issues operands to the MDU, counts its fixed latency, and captures results. It also raises the structural stall (MDU reused while busy) and the data stall (mfhi/mflo in ID while a result is pending), in the same style as the load-use stall detection.

## Interface
Parameters:
- MUL_LAT, 4: cycles from `mdu_start` to valid multiply result (≥1)
- DIV_LAT, 33: cycles from `mdu_start` to valid divide result (≥1, ≤63)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX-stage instruction is real (not a bubble)
- ex_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- ex_rs_val  in  32  forwarded rs value in EX
- ex_rt_val  in  32  forwarded rt value in EX
- id_reads_hilo  in  1  ID-stage instruction is mfhi/mflo
- mdu_hi_in  in  32  MDU high result / remainder
- mdu_lo_in  in  32  MDU low result / quotient
- mdu_start  out  1  one-cycle start pulse to MDU
- mdu_is_div  out  1  1 divide, 0 multiply (held while busy)
- mdu_signed  out  1  signed operation (held while busy)
- mdu_op_a  out  32  latched rs
- mdu_op_b  out  32  latched rt
- busy  out  1  operation in flight
- stall_ex  out  1  hold PC, IF/ID, ID/EX; bubble into EX/MEM
- stall_id  out  1  hold PC, IF/ID; bubble into ID/EX
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, BUSY. Down-counter `cnt` is 6 bits.
- IDLE with ex_valid and ex_op in 1..4 (issue cycle T): on the edge, latch ex_rs_val/ex_rt_val into op_a/op_b, set mdu_is_div and mdu_signed, load `cnt` with MUL_LAT or DIV_LAT, and go to BUSY. The issuing instruction leaves EX normally; the operation is non-blocking.
- BUSY: decrement `cnt` each cycle. When cnt==1, capture mdu_hi_in/mdu_lo_in into hi/lo on that edge and go to IDLE.
- mthi/mtlo in IDLE with ex_valid: write ex_rs_val into hi/lo on the edge. No stall.
- stall_ex = BUSY and ex_valid and ex_op in 1..6. The instruction is held in EX and issues or writes in the first IDLE cycle.
- stall_id = id_reads_hilo and (BUSY or issue cycle). Stalls are combinational from the current state and inputs.
- mthi in EX with mfhi in ID (IDLE): no stall. The register is written at the edge, and mfhi reads hi in EX on the next cycle.
- Ignored: ex_valid=0, ex_op 0/7. Divide-by-zero results are captured as the MDU returns them; no special casing.

## Timing
- Reset (synchronous): state IDLE, cnt 0, hi 0, lo 0, op_a 0, op_b 0, mdu_start 0, mdu_is_div 0, mdu_signed 0, busy 0, stall_ex 0, stall_id 0 (given id_reads_hilo=0).
- rst has priority over every event. A reset mid-operation aborts it: no later capture, and hi/lo become 0.
- Issue at cycle T:
  - mdu_start=1 in T+1 only.
  - busy=1 during T+1..T+LAT.
  - MDU result sampled at the end of T+LAT.
  - New hi/lo visible in T+LAT+1, with busy=0.
- LAT=1: start and capture both occur in T+1.
- Back-to-back MDU ops: the second is held during T+1..T+LAT, issues in T+LAT+1, and its mdu_start is in T+LAT+2.
- mtlo/mthi arriving during BUSY: held by stall_ex. The write lands at the end of T+LAT+1, after the capture, so it is not lost.

## Test plan
- Reset with all inputs 0 → every output 0 and hi=lo=0 on the first cycle after rst; holding rst for 3 cycles keeps this.
- mult with rs=0xFFFFFFFD, rt=5, MUL_LAT=4, bench MDU model → mdu_start high in T+1 only, op_a=0xFFFFFFFD, mdu_signed=1; busy during T+1..T+4; hi=0xFFFFFFFF and lo=0xFFFFFFF1 in T+5.
- divu 100/7 at T, mfhi in ID from T → stall_id high during T..T+33, low in T+34; hi=2 and lo=14 in T+34.
- mult at T, then div in EX at T+1 → stall_ex high during T+1..T+4; second mdu_start in T+6 with mdu_is_div=1; div result present in hi/lo in T+5+33+1.
- mthi 0x12345678 in IDLE → hi=0x12345678 next cycle, no stall. mtlo 0xCAFEBABE during a mult (MUL_LAT=4) → stall_ex until completion; final lo=0xCAFEBABE and hi=the mult result.
- div issued at T, rst at T+10 → busy=0 and hi=lo=0 in T+11; no hi/lo change at T+34; stall_ex and stall_id 0 after reset.

Source files
------------

// File: rtl/mdu_scheduler_if.sv
// Handshake bundle between the EX/ID pipeline stages, the MDU datapath and the MDU scheduler.
// The scheduler takes the slave view; whoever drives the pipeline side takes the master view.
interface mdu_scheduler_if;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic        id_reads_hilo;
    logic [31:0] mdu_hi_in;
    logic [31:0] mdu_lo_in;

    logic        mdu_start;
    logic        mdu_is_div;
    logic        mdu_signed;
    logic [31:0] mdu_op_a;
    logic [31:0] mdu_op_b;
    logic        busy;
    logic        stall_ex;
    logic        stall_id;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  ex_valid, ex_op, ex_rs_val, ex_rt_val, id_reads_hilo, mdu_hi_in, mdu_lo_in,
        output mdu_start, mdu_is_div, mdu_signed, mdu_op_a, mdu_op_b,
               busy, stall_ex, stall_id, hi, lo
    );

    modport master (
        output ex_valid, ex_op, ex_rs_val, ex_rt_val, id_reads_hilo, mdu_hi_in, mdu_lo_in,
        input  mdu_start, mdu_is_div, mdu_signed, mdu_op_a, mdu_op_b,
               busy, stall_ex, stall_id, hi, lo
    );
endinterface

// File: rtl/mdu_scheduler.sv
// Issues mult/div operations to the shared fixed-latency MDU, owns HI/LO, and raises the
// structural (EX) and data (ID) stalls while an MDU result is still pending.
module mdu_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic           clk,
    input  logic           rst,
    mdu_scheduler_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      r_state;
    state_t      w_nextState;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic        r_start;
    logic        r_isDiv;
    logic        r_signed;

    logic        w_isMdu;
    logic        w_isDivOp;
    logic        w_isMthi;
    logic        w_isMtlo;
    logic        w_issue;
    logic        w_capture;
    logic        w_writeHi;
    logic        w_writeLo;
    logic        w_stallEx;
    logic        w_stallId;

    always_comb begin
        w_isMdu   = bus.ex_valid && (bus.ex_op == OP_MULT || bus.ex_op == OP_MULTU ||
                                     bus.ex_op == OP_DIV  || bus.ex_op == OP_DIVU);
        w_isDivOp = (bus.ex_op == OP_DIV) || (bus.ex_op == OP_DIVU);
        w_isMthi  = bus.ex_valid && (bus.ex_op == OP_MTHI);
        w_isMtlo  = bus.ex_valid && (bus.ex_op == OP_MTLO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Anything touching HI/LO that reaches EX while busy is held there until the unit drains.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_writeHi   = 1'b0;
        w_writeLo   = 1'b0;
        w_stallEx   = 1'b0;
        w_stallId   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue   = w_isMdu;
                w_writeHi = w_isMthi;
                w_writeLo = w_isMtlo;
                if (w_isMdu) begin
                    w_nextState = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stallEx = w_isMdu || w_isMthi || w_isMtlo;
                if (r_cnt == 6'd1) begin
                    w_capture   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        w_stallId = bus.id_reads_hilo && ((r_state == S_BUSY) || w_issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 6'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opA    <= 32'd0;
            r_opB    <= 32'd0;
            r_start  <= 1'b0;
            r_isDiv  <= 1'b0;
            r_signed <= 1'b0;
        end else begin
            r_start <= w_issue;
            if (w_issue) begin
                r_opA    <= bus.ex_rs_val;
                r_opB    <= bus.ex_rt_val;
                r_isDiv  <= w_isDivOp;
                r_signed <= (bus.ex_op == OP_MULT) || (bus.ex_op == OP_DIV);
                r_cnt    <= w_isDivOp ? DIV_CNT : MUL_CNT;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 6'd1;
            end
            // Capture only happens in BUSY and moves only in IDLE, so these never collide.
            if (w_capture) begin
                r_hi <= bus.mdu_hi_in;
                r_lo <= bus.mdu_lo_in;
            end
            if (w_writeHi) begin
                r_hi <= bus.ex_rs_val;
            end
            if (w_writeLo) begin
                r_lo <= bus.ex_rs_val;
            end
        end
    end

    assign bus.mdu_start  = r_start;
    assign bus.mdu_is_div = r_isDiv;
    assign bus.mdu_signed = r_signed;
    assign bus.mdu_op_a   = r_opA;
    assign bus.mdu_op_b   = r_opB;
    assign bus.busy       = (r_state == S_BUSY);
    assign bus.stall_ex   = w_stallEx;
    assign bus.stall_id   = w_stallId;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler: a fixed-latency MDU model feeds results, and a negedge
// monitor pops expected start/result records whenever the DUT pulses start or drains.
module tb_mdu_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rstReq = 1'b1;

    always #5 clk = ~clk;

    mdu_scheduler_if ifc();

    mdu_scheduler #(.MUL_LAT(4), .DIV_LAT(33)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        isDiv;
        logic        sgn;
    } start_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

    start_t  startQ[$];
    result_t resultQ[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to the next cycle, drive the EX/ID inputs, then wait until mid-cycle.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic idReads);
        @(posedge clk);
        #1;
        rst               = rstReq;
        ifc.ex_valid      = v;
        ifc.ex_op         = op;
        ifc.ex_rs_val     = rs;
        ifc.ex_rt_val     = rt;
        ifc.id_reads_hilo = idReads;
        @(negedge clk);
    endtask

    task automatic expectStart(input logic [31:0] a, input logic [31:0] b, input logic d, input logic s);
        startQ.push_back('{a: a, b: b, isDiv: d, sgn: s});
    endtask

    task automatic expectResult(input logic [31:0] h, input logic [31:0] l);
        resultQ.push_back('{hi: h, lo: l});
    endtask

    // Fixed-latency MDU: the result is only valid in the cycle the scheduler must sample it.
    int mduAge = 0;
    always @(negedge clk) begin
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] prod;
        int lat;
        if (rst === 1'b1) mduAge = 0;
        else if (ifc.mdu_start === 1'b1) mduAge = 1;
        else if (mduAge != 0) mduAge++;
        lat = (ifc.mdu_is_div === 1'b1) ? 33 : 4;
        ifc.mdu_hi_in = 32'hDEADBEEF;
        ifc.mdu_lo_in = 32'hDEADBEEF;
        if (mduAge == lat) begin
            if (ifc.mdu_is_div !== 1'b1) begin
                sa = {{32{ifc.mdu_op_a[31]}}, ifc.mdu_op_a};
                sb = {{32{ifc.mdu_op_b[31]}}, ifc.mdu_op_b};
                prod = ifc.mdu_signed ? 64'(sa * sb) : ({32'd0, ifc.mdu_op_a} * {32'd0, ifc.mdu_op_b});
                ifc.mdu_hi_in = prod[63:32];
                ifc.mdu_lo_in = prod[31:0];
            end else if (ifc.mdu_op_b == 32'd0) begin
                ifc.mdu_hi_in = ifc.mdu_op_a;
                ifc.mdu_lo_in = 32'hFFFFFFFF;
            end else if (ifc.mdu_signed) begin
                ifc.mdu_lo_in = $signed(ifc.mdu_op_a) / $signed(ifc.mdu_op_b);
                ifc.mdu_hi_in = $signed(ifc.mdu_op_a) % $signed(ifc.mdu_op_b);
            end else begin
                ifc.mdu_lo_in = ifc.mdu_op_a / ifc.mdu_op_b;
                ifc.mdu_hi_in = ifc.mdu_op_a % ifc.mdu_op_b;
            end
        end
    end

    // Scoreboard monitor: start pulses and completed (non-aborted) operations pop the queues.
    logic prevBusy = 1'b0;
    logic prevRst = 1'b1;
    always @(negedge clk) begin
        start_t  s;
        result_t r;
        if (ifc.mdu_start === 1'b1) begin
            if (startQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_start: got op_a %h, expected no start", ifc.mdu_op_a);
            end else begin
                s = startQ.pop_front();
                checkOutput("start_op_a", ifc.mdu_op_a, s.a);
                checkOutput("start_op_b", ifc.mdu_op_b, s.b);
                checkOutput("start_is_div", 32'(ifc.mdu_is_div), 32'(s.isDiv));
                checkOutput("start_signed", 32'(ifc.mdu_signed), 32'(s.sgn));
            end
        end
        if (prevBusy && ifc.busy === 1'b0 && !prevRst) begin
            if (resultQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_result: got hi %h lo %h, expected none", ifc.hi, ifc.lo);
            end else begin
                r = resultQ.pop_front();
                checkOutput("result_hi", ifc.hi, r.hi);
                checkOutput("result_lo", ifc.lo, r.lo);
            end
        end
        prevBusy = (ifc.busy === 1'b1);
        prevRst  = (rst === 1'b1);
    end

    initial begin
        ifc.ex_valid      = 1'b0;
        ifc.ex_op         = 3'd0;
        ifc.ex_rs_val     = 32'd0;
        ifc.ex_rt_val     = 32'd0;
        ifc.id_reads_hilo = 1'b0;

        $display("[TB] reset held for 3 cycles");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("reset_busy", 32'(ifc.busy), 0);
            checkOutput("reset_start", 32'(ifc.mdu_start), 0);
            checkOutput("reset_stall_ex", 32'(ifc.stall_ex), 0);
            checkOutput("reset_stall_id", 32'(ifc.stall_id), 0);
            checkOutput("reset_hi", ifc.hi, 0);
            checkOutput("reset_lo", ifc.lo, 0);
            checkOutput("reset_op_a", ifc.mdu_op_a, 0);
            checkOutput("reset_flags", {30'd0, ifc.mdu_is_div, ifc.mdu_signed}, 0);
        end
        rstReq = 1'b0;

        $display("[TB] mult -3 * 5");
        applyStimulus(1, 3'd1, 32'hFFFFFFFD, 32'd5, 0);
        expectStart(32'hFFFFFFFD, 32'd5, 0, 1);
        expectResult(32'hFFFFFFFF, 32'hFFFFFFF1);
        checkOutput("mult_T_busy", 32'(ifc.busy), 0);
        checkOutput("mult_T_start", 32'(ifc.mdu_start), 0);
        checkOutput("mult_T_stall_ex", 32'(ifc.stall_ex), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mult_T1_start", 32'(ifc.mdu_start), 1);
        checkOutput("mult_T1_busy", 32'(ifc.busy), 1);
        checkOutput("mult_T1_op_a", ifc.mdu_op_a, 32'hFFFFFFFD);
        checkOutput("mult_T1_signed", 32'(ifc.mdu_signed), 1);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("mult_busy", 32'(ifc.busy), 1);
            checkOutput("mult_start_low", 32'(ifc.mdu_start), 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mult_T5_busy", 32'(ifc.busy), 0);
        checkOutput("mult_T5_hi", ifc.hi, 32'hFFFFFFFF);
        checkOutput("mult_T5_lo", ifc.lo, 32'hFFFFFFF1);

        $display("[TB] divu 100 / 7 with mfhi waiting in ID");
        applyStimulus(1, 3'd4, 32'd100, 32'd7, 1);
        expectStart(32'd100, 32'd7, 1, 0);
        expectResult(32'd2, 32'd14);
        checkOutput("divu_T_stall_id", 32'(ifc.stall_id), 1);
        for (int k = 1; k <= 33; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput("divu_stall_id", 32'(ifc.stall_id), 1);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("divu_T34_stall_id", 32'(ifc.stall_id), 0);
        checkOutput("divu_T34_hi", ifc.hi, 32'd2);
        checkOutput("divu_T34_lo", ifc.lo, 32'd14);

        $display("[TB] mult 6*7 followed by div -20/3");
        applyStimulus(1, 3'd1, 32'd6, 32'd7, 0);
        expectStart(32'd6, 32'd7, 0, 1);
        expectResult(32'd0, 32'd42);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 3'd3, 32'hFFFFFFEC, 32'd3, 0);
            checkOutput("b2b_stall_ex", 32'(ifc.stall_ex), 1);
        end
        applyStimulus(1, 3'd3, 32'hFFFFFFEC, 32'd3, 0);
        expectStart(32'hFFFFFFEC, 32'd3, 1, 1);
        expectResult(32'hFFFFFFFE, 32'hFFFFFFFA);
        checkOutput("b2b_T5_stall_ex", 32'(ifc.stall_ex), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_T6_start", 32'(ifc.mdu_start), 1);
        checkOutput("b2b_T6_is_div", 32'(ifc.mdu_is_div), 1);
        for (int k = 7; k <= 38; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("b2b_div_busy", 32'(ifc.busy), 1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_T39_busy", 32'(ifc.busy), 0);
        checkOutput("b2b_T39_hi", ifc.hi, 32'hFFFFFFFE);
        checkOutput("b2b_T39_lo", ifc.lo, 32'hFFFFFFFA);

        $display("[TB] mthi in idle with mfhi in ID");
        applyStimulus(1, 3'd5, 32'h12345678, 0, 1);
        checkOutput("mthi_stall_id", 32'(ifc.stall_id), 0);
        checkOutput("mthi_stall_ex", 32'(ifc.stall_ex), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mthi_hi", ifc.hi, 32'h12345678);
        checkOutput("mthi_lo_kept", ifc.lo, 32'hFFFFFFFA);

        $display("[TB] mtlo held behind multu");
        applyStimulus(1, 3'd2, 32'h00010000, 32'h00010000, 0);
        expectStart(32'h00010000, 32'h00010000, 0, 0);
        expectResult(32'd1, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 3'd6, 32'hCAFEBABE, 0, 0);
            checkOutput("mtlo_stall_ex", 32'(ifc.stall_ex), 1);
        end
        applyStimulus(1, 3'd6, 32'hCAFEBABE, 0, 0);
        checkOutput("mtlo_T5_stall_ex", 32'(ifc.stall_ex), 0);
        checkOutput("mtlo_T5_lo", ifc.lo, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mtlo_final_lo", ifc.lo, 32'hCAFEBABE);
        checkOutput("mtlo_final_hi", ifc.hi, 32'd1);

        $display("[TB] div aborted by reset");
        applyStimulus(1, 3'd3, 32'd50, 32'd5, 0);
        expectStart(32'd50, 32'd5, 1, 1);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("abort_T9_busy", 32'(ifc.busy), 1);
        rstReq = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        rstReq = 1'b0;
        applyStimulus(1, 3'd0, 32'h55555555, 0, 1);
        checkOutput("abort_T11_busy", 32'(ifc.busy), 0);
        checkOutput("abort_T11_hi", ifc.hi, 0);
        checkOutput("abort_T11_lo", ifc.lo, 0);
        checkOutput("abort_T11_stall_ex", 32'(ifc.stall_ex), 0);
        checkOutput("abort_T11_stall_id", 32'(ifc.stall_id), 0);
        for (int k = 12; k <= 40; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("abort_hi_quiet", ifc.hi, 0);
            checkOutput("abort_lo_quiet", ifc.lo, 0);
        end

        checkOutput("start_queue_drained", 32'(startQ.size()), 0);
        checkOutput("result_queue_drained", 32'(resultQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
